// File: rtl/vector_control_unit.sv
// Vector control unit: IDLE/EXEC/HALT sequencer issuing per-lane control strobes.
// Scalar opcodes take one step; vector opcodes step through LANES lanes.
module vector_control_unit #(
    parameter int OP_W   = 4,
    parameter int LANES  = 4,
    parameter int LANE_W = ($clog2(LANES) > 0) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [OP_W-1:0]   operation,
    input  logic              stall,
    input  logic              flush,
    output logic              instr_ready,
    output logic              regWrite,
    output logic              memWrite,
    output logic              branch,
    output logic [1:0]        resultSrc,
    output logic [OP_W-1:0]   aluControl,
    output logic [LANE_W-1:0] lane_idx,
    output logic              busy,
    output logic              halted
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]        r_state;
    logic [OP_W-1:0]   r_op;
    logic [LANE_W-1:0] r_lane;

    logic w_in_end;
    logic w_scalar;
    logic w_last_lane;
    logic w_last_step;
    logic w_exec;
    logic w_mask;
    logic w_rw;
    logic w_mw;
    logic w_br;
    logic [1:0]      w_rs;
    logic [OP_W-1:0] w_alu;

    assign w_in_end    = (operation == '0) || (operation >= OP_W'(13));
    assign w_scalar    = (r_op <= OP_W'(3));
    assign w_last_lane = (r_lane == LANE_W'(LANES - 1));
    assign w_last_step = w_scalar || w_last_lane;
    assign w_exec      = (r_state == S_EXEC);
    assign w_mask      = stall || flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_lane  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid && !flush) begin
                        r_op    <= operation;
                        r_lane  <= '0;
                        r_state <= w_in_end ? S_HALT : S_EXEC;
                    end
                end
                S_EXEC: begin
                    // flush outranks stall; stall freezes lane and state
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_lane  <= '0;
                    end else if (!stall) begin
                        if (w_last_step) begin
                            r_state <= S_IDLE;
                            r_lane  <= '0;
                        end else begin
                            r_lane <= r_lane + LANE_W'(1);
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_rw  = 1'b0;
        w_mw  = 1'b0;
        w_br  = 1'b0;
        w_rs  = 2'd0;
        w_alu = '0;
        if (w_exec) begin
            w_alu = r_op;
            unique case (1'b1)
                (r_op <= OP_W'(4)): begin
                    w_rw = 1'b1;
                end
                (r_op == OP_W'(5)): begin
                    w_rw = 1'b1;
                    w_rs = 2'd1;
                end
                (r_op == OP_W'(6)): begin
                    w_mw = 1'b1;
                    w_rs = 2'd1;
                end
                (r_op == OP_W'(7)) || (r_op == OP_W'(8)): begin
                    w_br = w_last_lane;
                    w_rs = 2'd1;
                end
                default: begin
                    w_rs = 2'd0;
                end
            endcase
        end
    end

    assign regWrite    = w_rw && !w_mask;
    assign memWrite    = w_mw && !w_mask;
    assign branch      = w_br && !w_mask;
    assign resultSrc   = w_rs;
    assign aluControl  = w_alu;
    assign lane_idx    = r_lane;
    assign instr_ready = (r_state == S_IDLE);
    assign busy        = w_exec;
    assign halted      = (r_state == S_HALT);

endmodule
